// File: rtl/data_ram_wait_pkg.sv
// Shared encodings for the MEM-stage data RAM: access sizes, handshake FSM states,
// and the byte count that belongs to each size.
package data_ram_wait_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Reserved size reports zero bytes; it is rejected before the byte count matters.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Byte-wide storage: big-endian 4-byte combinational read at an aligned base and a
// synchronous write gated per byte lane (be_i[3] is the byte at base_i).
module data_ram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] base_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [7:0] Mem [0:DEPTH-1];

  assign rdata_o = {Mem[base_i], Mem[base_i + AW'(1)],
                    Mem[base_i + AW'(2)], Mem[base_i + AW'(3)]};

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[3-i]) Mem[base_i + AW'(i)] <= wdata_i[8*(3-i) +: 8];
      end
    end
  end

endmodule

// File: rtl/data_ram_wait.sv
// Data RAM for the MEM stage with req/ready handshake, programmable wait states,
// big-endian byte/half/word access with optional sign extension, and fault reporting.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | ready to accept a request on Enable
//   ST_WAIT | counting down wait states; inputs ignored
//   ST_RESP | Ready pulse (with Fault for a rejected request)
module data_ram_wait
  import data_ram_wait_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Enable,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  output logic [31:0]       DataOut,
  output logic              Ready,
  output logic              Fault
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rw_q, sext_q, bad_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         din_q, dout_q;
  logic [1:0]          size_q;
  logic                accept, commit, bad_in;
  logic [ADDR_W:0]     end_addr;

  assign end_addr = {1'b0, Address} + (ADDR_W+1)'(size_bytes(Size));
  assign bad_in   = (Size == SZ_RSVD)
                  | ((Size == SZ_HALF) & Address[0])
                  | ((Size == SZ_WORD) & (|Address[1:0]))
                  | (end_addr > (ADDR_W+1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          accept = 1'b1;
          if (bad_in) begin
            state_d = ST_RESP;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, before capture.
  logic              in_idle;
  logic              op_rw, op_sext;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_din;
  logic [1:0]        op_size, op_off;

  assign in_idle = (state_q == ST_IDLE);
  assign op_rw   = in_idle ? RW      : rw_q;
  assign op_sext = in_idle ? SignExt : sext_q;
  assign op_addr = in_idle ? Address : addr_q;
  assign op_din  = in_idle ? DataIn  : din_q;
  assign op_size = in_idle ? Size    : size_q;
  assign op_off  = op_addr[1:0];

  logic [AW-1:0] base;
  logic [3:0]    be;
  logic [31:0]   wdata, rd_word, rd_ext;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  assign base = AW'(op_addr) & ~AW'(3);

  always_comb begin
    be     = 4'b0000;
    wdata  = op_din;
    rd_ext = rd_word;
    case (op_off)
      2'd0:    rd_byte = rd_word[31:24];
      2'd1:    rd_byte = rd_word[23:16];
      2'd2:    rd_byte = rd_word[15:8];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = op_off[1] ? rd_word[15:0] : rd_word[31:16];
    case (op_size)
      SZ_BYTE: begin
        be     = 4'b1000 >> op_off;
        wdata  = {4{op_din[7:0]}};
        rd_ext = {{24{op_sext & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        be     = op_off[1] ? 4'b0011 : 4'b1100;
        wdata  = {2{op_din[15:0]}};
        rd_ext = {{16{op_sext & rd_half[15]}}, rd_half};
      end
      default: begin
        be     = 4'b1111;
        wdata  = op_din;
        rd_ext = rd_word;
      end
    endcase
  end

  data_ram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk_i   (clk),
    .we_i    (commit & op_rw),
    .be_i    (be),
    .base_i  (base),
    .wdata_i (wdata),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      sext_q  <= 1'b0;
      bad_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      size_q  <= 2'b00;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rw_q   <= RW;
        sext_q <= SignExt;
        bad_q  <= bad_in;
        addr_q <= Address;
        din_q  <= DataIn;
        size_q <= Size;
      end
      if (commit && !op_rw) dout_q <= rd_ext;
    end
  end

  assign DataOut = dout_q;
  assign Ready   = (state_q == ST_RESP);
  assign Fault   = (state_q == ST_RESP) & bad_q;

endmodule

// File: tb/tb_data_ram_wait.sv
// Directed bench for data_ram_wait: three instances with 2, 3 and 1 wait states
// sharing request fields, each with its own Enable and reset.
module tb_data_ram_wait;

  logic        clk;
  logic        rstn [3];
  logic        en   [3];
  logic        rw, sext;
  logic [31:0] addr, din;
  logic [1:0]  size;
  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        flt  [3];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  data_ram_wait #(.DEPTH(256), .WAIT_STATES(2), .ADDR_W(32)) dut0 (
    .clk(clk), .rst_n(rstn[0]), .Enable(en[0]), .RW(rw), .Address(addr), .DataIn(din),
    .Size(size), .SignExt(sext), .DataOut(dout[0]), .Ready(rdy[0]), .Fault(flt[0]));
  data_ram_wait #(.DEPTH(256), .WAIT_STATES(3), .ADDR_W(32)) dut1 (
    .clk(clk), .rst_n(rstn[1]), .Enable(en[1]), .RW(rw), .Address(addr), .DataIn(din),
    .Size(size), .SignExt(sext), .DataOut(dout[1]), .Ready(rdy[1]), .Fault(flt[1]));
  data_ram_wait #(.DEPTH(256), .WAIT_STATES(1), .ADDR_W(32)) dut2 (
    .clk(clk), .rst_n(rstn[2]), .Enable(en[2]), .RW(rw), .Address(addr), .DataIn(din),
    .Size(size), .SignExt(sext), .DataOut(dout[2]), .Ready(rdy[2]), .Fault(flt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request on instance k; lat = edges after acceptance at which Ready is seen (0 = none).
  task automatic req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic sx,
                     output int lat, output logic f, output logic [31:0] q);
    @(negedge clk);
    rw = w; addr = a; din = d; size = sz; sext = sx; en[k] = 1'b1;
    @(posedge clk);
    #1 en[k] = 1'b0;
    lat = 0; f = 1'b0; q = 32'h0;
    for (int n = 1; n <= 30 && lat == 0; n++) begin
      @(negedge clk);
      if (rdy[k] === 1'b1) begin
        lat = n; f = flt[k]; q = dout[k];
      end
    end
  endtask

  task automatic preload(input int k);
    int lat; logic f; logic [31:0] q;
    req(k, 1'b1, 32'd0,  32'h12345678, W, 1'b0, lat, f, q);
    req(k, 1'b1, 32'd4,  32'h8001FF7F, W, 1'b0, lat, f, q);
    req(k, 1'b1, 32'd12, 32'h11223344, W, 1'b0, lat, f, q);
  endtask

  task automatic test_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (dout[k] !== 32'h0 || rdy[k] !== 1'b0 || flt[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got dout=%h rdy=%b flt=%b, expected 0/0/0",
                 k, dout[k], rdy[k], flt[k]);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
  endtask

  task automatic test_word_read();
    int lat; logic f; logic [31:0] q;
    req(0, 1'b0, 32'd0, 32'h0, W, 1'b0, lat, f, q);
    n_checks++;
    if (lat !== 3 || f !== 1'b0 || q !== 32'h12345678) begin
      n_fail++;
      $display("FAIL word_read: got lat=%0d fault=%b data=%h, expected 3/0/12345678", lat, f, q);
    end
    @(negedge clk);
    n_checks++;
    if (rdy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_pulse_width: got Ready=%b one cycle later, expected 0", rdy[0]);
    end
  endtask

  task automatic test_extension();
    logic [31:0] ta [6] = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd6, 32'd6};
    logic [1:0]  ts [6] = '{B, B, H, H, H, H};
    logic        tx [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                            32'h00008001, 32'hFFFFFF7F, 32'h0000FF7F};
    int lat; logic f; logic [31:0] q;
    for (int i = 0; i < 6; i++) begin
      req(0, 1'b0, ta[i], 32'h0, ts[i], tx[i], lat, f, q);
      n_checks++;
      if (lat !== 3 || f !== 1'b0 || q !== te[i]) begin
        n_fail++;
        $display("FAIL extend_read[%0d]: got lat=%0d fault=%b data=%h, expected 3/0/%h",
                 i, lat, f, q, te[i]);
      end
    end
  endtask

  task automatic test_write();
    logic [31:0] wa [3] = '{32'd0, 32'd2, 32'd8};
    logic [31:0] wd [3] = '{32'h000000AA, 32'h0000BBBB, 32'hDDDDDDDD};
    logic [1:0]  ws [3] = '{B, H, W};
    int lat; logic f; logic [31:0] q;
    req(0, 1'b0, 32'd0, 32'h0, W, 1'b0, lat, f, q);
    for (int i = 0; i < 3; i++) begin
      req(0, 1'b1, wa[i], wd[i], ws[i], 1'b0, lat, f, q);
      n_checks++;
      if (lat !== 3 || f !== 1'b0 || q !== 32'h12345678) begin
        n_fail++;
        $display("FAIL write[%0d]: got lat=%0d fault=%b data=%h, expected 3/0/12345678",
                 i, lat, f, q);
      end
    end
    req(0, 1'b0, 32'd0, 32'h0, W, 1'b0, lat, f, q);
    n_checks++;
    if (q !== 32'hAA34BBBB) begin
      n_fail++;
      $display("FAIL readback_0: got %h, expected AA34BBBB", q);
    end
    req(0, 1'b0, 32'd8, 32'h0, W, 1'b0, lat, f, q);
    n_checks++;
    if (q !== 32'hDDDDDDDD) begin
      n_fail++;
      $display("FAIL readback_8: got %h, expected DDDDDDDD", q);
    end
  endtask

  task automatic test_bad();
    logic        br [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] ba [7] = '{32'd1, 32'd6, 32'd0, 32'd254, 32'd254, 32'd255, 32'd256};
    logic [1:0]  bs [7] = '{H, W, R, W, W, H, B};
    int lat; logic f; logic [31:0] q;
    req(0, 1'b1, 32'd252, 32'hA5A5A5A5, W, 1'b0, lat, f, q);
    req(0, 1'b0, 32'd252, 32'h0, W, 1'b0, lat, f, q);
    n_checks++;
    if (lat !== 3 || f !== 1'b0 || q !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL top_word: got lat=%0d fault=%b data=%h, expected 3/0/A5A5A5A5", lat, f, q);
    end
    req(0, 1'b0, 32'd255, 32'h0, B, 1'b0, lat, f, q);
    n_checks++;
    if (lat !== 3 || f !== 1'b0 || q !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL top_byte: got lat=%0d fault=%b data=%h, expected 3/0/000000A5", lat, f, q);
    end
    for (int i = 0; i < 7; i++) begin
      req(0, br[i], ba[i], 32'hFFFFFFFF, bs[i], 1'b1, lat, f, q);
      n_checks++;
      if (lat !== 1 || f !== 1'b1 || q !== 32'h000000A5) begin
        n_fail++;
        $display("FAIL bad_req[%0d]: got lat=%0d fault=%b data=%h, expected 1/1/000000A5",
                 i, lat, f, q);
      end
    end
    req(0, 1'b0, 32'd0, 32'h0, W, 1'b0, lat, f, q);
    n_checks++;
    if (q !== 32'hAA34BBBB) begin
      n_fail++;
      $display("FAIL bad_mem_0: got %h, expected AA34BBBB", q);
    end
    req(0, 1'b0, 32'd4, 32'h0, W, 1'b0, lat, f, q);
    n_checks++;
    if (q !== 32'h8001FF7F) begin
      n_fail++;
      $display("FAIL bad_mem_4: got %h, expected 8001FF7F", q);
    end
  endtask

  task automatic test_reset_abort();
    int lat; int pulses; logic f; logic [31:0] q;
    req(1, 1'b0, 32'd0, 32'h0, W, 1'b0, lat, f, q);
    n_checks++;
    if (lat !== 4 || q !== 32'h12345678) begin
      n_fail++;
      $display("FAIL ws3_read: got lat=%0d data=%h, expected 4/12345678", lat, q);
    end
    @(negedge clk);
    rw = 1'b1; addr = 32'd12; din = 32'hCAFEF00D; size = W; sext = 1'b0; en[1] = 1'b1;
    @(posedge clk);
    #1 en[1] = 1'b0;
    @(posedge clk);
    #1 rstn[1] = 1'b0;
    #1;
    n_checks++;
    if (rdy[1] !== 1'b0 || flt[1] !== 1'b0 || dout[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got rdy=%b flt=%b dout=%h, expected 0/0/0",
               rdy[1], flt[1], dout[1]);
    end
    @(negedge clk);
    rstn[1] = 1'b1;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (rdy[1] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_no_ready: got %0d Ready pulses, expected 0", pulses);
    end
    req(1, 1'b0, 32'd12, 32'h0, W, 1'b0, lat, f, q);
    n_checks++;
    if (lat !== 4 || f !== 1'b0 || q !== 32'h11223344) begin
      n_fail++;
      $display("FAIL abort_no_write: got lat=%0d fault=%b data=%h, expected 4/0/11223344",
               lat, f, q);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_r [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] exp_d [10];
    logic        got_r [10];
    logic [31:0] got_d [10];
    int pulses;
    exp_d[1] = 32'h12345678; exp_d[4] = 32'h8001FF7F; exp_d[7] = 32'h12345678;
    @(negedge clk);
    rw = 1'b0; addr = 32'd0; din = 32'h0; size = W; sext = 1'b0; en[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 if (c == 9) en[2] = 1'b0;
      @(negedge clk);
      got_r[c] = rdy[2];
      got_d[c] = dout[2];
      if (c == 0) addr = 32'd4;
      if (c == 3) addr = 32'd0;
    end
    pulses = 0;
    for (int c = 0; c < 10; c++) if (got_r[c] === 1'b1) pulses++;
    n_checks++;
    if (pulses !== 3) begin
      n_fail++;
      $display("FAIL b2b_pulse_count: got %0d, expected 3", pulses);
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (got_r[c] !== exp_r[c] || (exp_r[c] && got_d[c] !== exp_d[c])) begin
        n_fail++;
        $display("FAIL b2b_cycle[%0d]: got rdy=%b data=%h, expected rdy=%b data=%h",
                 c, got_r[c], got_d[c], exp_r[c], exp_d[c]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0;
      en[k]   = 1'b0;
    end
    rw = 1'b0; sext = 1'b0; addr = 32'h0; din = 32'h0; size = W;
    test_reset();
    preload(0);
    preload(1);
    preload(2);
    test_word_read();
    test_extension();
    test_write();
    test_bad();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
